// File: rtl/l32_mod_accumulator.sv
// l32_mod_accumulator: streaming mod-(2^32-1) frame accumulator.
// Operands arrive over valid/ready and are folded into a running sum through
// one L32_adder. Each frame result appears on a registered valid/ready output,
// together with a saturating beat count and a saturation flag.

// L32_adder: 32-bit end-around-carry adder (one's-complement / mod 2^32-1).
// The carry out of bit 31 is fed back into bit 0. The second add cannot
// overflow: if the carry is set, the low word is at most 2^32-2.
module L32_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    logic [32:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum = w_raw[31:0] + {31'd0, w_raw[32]};
endmodule

module l32_mod_accumulator #(
    parameter int COUNT_W   = 16,
    parameter bit NORMALIZE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_sat
);
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Saturating beat-counter increment.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == CNT_MAX) ? CNT_MAX : (c + CNT_ONE);
    endfunction

    // Map the redundant zero 0xFFFFFFFF to 0 when normalisation is enabled.
    function automatic logic [31:0] norm(input logic [31:0] v);
        return (NORMALIZE && (v == 32'hFFFF_FFFF)) ? 32'd0 : v;
    endfunction

    state_t               r_state;
    logic [31:0]          r_acc;
    logic [COUNT_W-1:0]   r_cnt;
    logic                 r_sat;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [31:0]          r_out_data;
    logic [COUNT_W-1:0]   r_out_count;
    logic                 r_out_sat;

    state_t               w_state;
    logic [31:0]          w_acc;
    logic [COUNT_W-1:0]   w_cnt;
    logic                 w_sat;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [31:0]          w_out_data;
    logic [COUNT_W-1:0]   w_out_count;
    logic                 w_out_sat;

    logic [31:0]          w_sum;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_cnt_max;

    L32_adder u_adder (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_xfer    = r_out_valid && out_ready;
    assign w_cnt_max = (r_cnt == CNT_MAX);

    // Next-state and next-output logic; everything holds unless a beat or a result moves.
    always_comb begin
        w_state     = r_state;
        w_acc       = r_acc;
        w_cnt       = r_cnt;
        w_sat       = r_sat;
        w_out_data  = r_out_data;
        w_out_count = r_out_count;
        w_out_sat   = r_out_sat;

        case (r_state)
            ST_ACC: begin
                if (w_accept && in_last) begin
                    // Close the frame: publish the result and clear for the next frame.
                    w_out_data  = norm(w_sum);
                    w_out_count = sat_inc(r_cnt);
                    w_out_sat   = r_sat | w_cnt_max;
                    w_acc       = 32'd0;
                    w_cnt       = {COUNT_W{1'b0}};
                    w_sat       = 1'b0;
                    w_state     = ST_HOLD;
                end else if (w_accept) begin
                    w_acc = w_sum;
                    w_cnt = sat_inc(r_cnt);
                    w_sat = r_sat | w_cnt_max;
                end else begin
                    w_state = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (w_xfer) begin
                    w_state = ST_ACC;
                end else begin
                    w_state = ST_HOLD;
                end
            end
            default: begin
                w_state = ST_ACC;
            end
        endcase

        // Handshake outputs follow the state being entered, so they are plain flops.
        w_in_ready  = (w_state == ST_ACC);
        w_out_valid = (w_state == ST_HOLD);
    end

    // State and output registers; reset discards any partial frame or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= 32'd0;
            r_cnt       <= {COUNT_W{1'b0}};
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_count <= {COUNT_W{1'b0}};
            r_out_sat   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_acc       <= w_acc;
            r_cnt       <= w_cnt;
            r_sat       <= w_sat;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_count <= w_out_count;
            r_out_sat   <= w_out_sat;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;
endmodule

// File: tb/tb_l32_mod_accumulator.sv
// Directed, table-driven bench for l32_mod_accumulator. Three instances share
// one stimulus stream: default parameters, NORMALIZE=0 and COUNT_W=2.
module tb_l32_mod_accumulator;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  in_ready_r,  in_ready_c;
    logic        out_valid, out_valid_r, out_valid_c;
    logic [31:0] out_data,  out_data_r,  out_data_c;
    logic [15:0] out_count, out_count_r;
    logic [1:0]  out_count_c;
    logic        out_sat,   out_sat_r,   out_sat_c;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]       len;
        logic [4:0][31:0] beats;
        logic [31:0]      exp_norm;
        logic [31:0]      exp_raw;
        logic [15:0]      exp_cnt;
        logic [1:0]       exp_cnt2;
        logic             exp_sat2;
    } vec_t;

    vec_t vecs [9];

    l32_mod_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .out_sat(out_sat)
    );

    l32_mod_accumulator #(.COUNT_W(16), .NORMALIZE(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_data(out_data_r), .out_count(out_count_r),
        .out_sat(out_sat_r)
    );

    l32_mod_accumulator #(.COUNT_W(2), .NORMALIZE(1'b1)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_count(out_count_c),
        .out_sat(out_sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3,
                                input logic [31:0] b4,
                                input logic [31:0] en, input logic [31:0] er,
                                input int c, input int c2, input logic s2);
        vec_t v;
        v.len      = 3'(n);
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        v.beats[4] = b4;
        v.exp_norm = en;
        v.exp_raw  = er;
        v.exp_cnt  = 16'(c);
        v.exp_cnt2 = 2'(c2);
        v.exp_sat2 = s2;
        return v;
    endfunction

    // Drive one frame, then check the result on the cycle after the last beat.
    task automatic run_frame(input vec_t v, input string tag);
        int g;
        for (int i = 0; i < int'(v.len); i++) begin
            in_valid = 1'b1;
            in_data  = v.beats[i];
            in_last  = (i == int'(v.len) - 1);
            g = 0;
            while (in_ready !== 1'b1 && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 20) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
            if (in_last) chk({tag, "_valid_before"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_valid"},    32'(out_valid),   32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready),    32'd0);
        chk({tag, "_data"},     out_data,         v.exp_norm);
        chk({tag, "_data_raw"}, out_data_r,       v.exp_raw);
        chk({tag, "_count"},    32'(out_count),   32'(v.exp_cnt));
        chk({tag, "_sat"},      32'(out_sat),     32'd0);
        chk({tag, "_count2"},   32'(out_count_c), 32'(v.exp_cnt2));
        chk({tag, "_sat2"},     32'(out_sat_c),   32'(v.exp_sat2));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready_after"}, 32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        //           len b0            b1            b2            b3    b4    norm          raw           cnt c2 s2
        vecs[0] = mk(3, 32'd3,        32'd5,        32'd7,        32'd0, 32'd0, 32'h0000000F, 32'h0000000F, 3, 3, 1'b0);
        vecs[1] = mk(2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 32'd0, 32'h00000001, 32'h00000001, 2, 2, 1'b0);
        vecs[2] = mk(2, 32'hFFFFFFFE, 32'd1,        32'd0,        32'd0, 32'd0, 32'h00000000, 32'hFFFFFFFF, 2, 2, 1'b0);
        vecs[3] = mk(1, 32'h80000000, 32'd0,        32'd0,        32'd0, 32'd0, 32'h80000000, 32'h80000000, 1, 1, 1'b0);
        vecs[4] = mk(2, 32'h80000000, 32'h80000000, 32'd0,        32'd0, 32'd0, 32'h00000001, 32'h00000001, 2, 2, 1'b0);
        vecs[5] = mk(2, 32'd7,        32'hFFFFFFFF, 32'd0,        32'd0, 32'd0, 32'h00000007, 32'h00000007, 2, 2, 1'b0);
        vecs[6] = mk(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0, 32'd0, 32'h00000000, 32'hFFFFFFFF, 2, 2, 1'b0);
        vecs[7] = mk(1, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0, 32'd0, 32'h00000000, 32'hFFFFFFFF, 1, 1, 1'b0);
        vecs[8] = mk(5, 32'd1,        32'd1,        32'd1,        32'd1, 32'd1, 32'h00000005, 32'h00000005, 5, 3, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd0);
        chk("rst_data",     out_data,       32'd0);
        chk("rst_count",    32'(out_count), 32'd0);
        chk("rst_sat",      32'(out_sat),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_rise", 32'(in_ready), 32'd1);

        // Table of frames, out_ready held high
        for (int k = 0; k < 9; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: result held while out_ready is low; junk offered upstream is ignored
        out_ready = 1'b0;
        run_frame(vecs[0], "bp");
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", c),    32'(out_valid), 32'd1);
            chk($sformatf("bp_data_%0d", c),     out_data,       32'h0000000F);
            chk($sformatf("bp_count_%0d", c),    32'(out_count), 32'd3);
            chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Reset in mid-frame: two beats accepted, then reset discards them
        in_valid = 1'b1;
        in_data  = 32'd1;
        in_last  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(out_valid),   32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),    32'd0);
        chk("mid_rst_data",     out_data,         32'd0);
        chk("mid_rst_count",    32'(out_count),   32'd0);
        chk("mid_rst_count2",   32'(out_count_c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_rise", 32'(in_ready), 32'd1);
        run_frame(mk(2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2, 2, 2, 1'b0), "post_rst");

        // Variants share the handshake, so their flags must agree with the default instance
        chk("var_ready_raw", 32'(in_ready_r),  32'(in_ready));
        chk("var_ready_c2",  32'(in_ready_c),  32'(in_ready));
        chk("var_valid_raw", 32'(out_valid_r), 32'd0);
        chk("var_valid_c2",  32'(out_valid_c), 32'd0);
        chk("var_sat_raw",   32'(out_sat_r),   32'd0);
        chk("var_cnt_raw",   32'(out_count_r), 32'd2);
        chk("var_data_c2",   out_data_c,       32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l32_mod_accumulator.md
Name: l32_mod_accumulator

Overview:
Streaming accumulator modulo 2^32-1 that sits directly downstream of the team's 32-bit Ling end-around-carry adder (L32_adder) and feeds its sum back as an operand.
- Accepts a frame of 32-bit operands over a valid/ready handshake and sums them modulo 2^32-1, one operand per cycle, through one L32_adder instance.
- Presents the frame result, beat count and saturation flag on a registered valid/ready output.
- Used by the residue-arithmetic path wherever a running mod-(2^32-1) sum is needed.

Parameters:
COUNT_W, 16, width of beat counter / out_count.
NORMALIZE, 1, 1 = map result 0xFFFFFFFF (the redundant zero) to 0x00000000 on out_data; 0 = pass the raw value.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand valid.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  32  operand, modulo 2^32-1 encoding.
in_last  input  1  qualifies the final beat of a frame.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  32  frame sum modulo 2^32-1.
out_count  output  COUNT_W  beats in frame, saturating.
out_sat  output  1  beat count saturated during the frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACC, acc=0, cnt=0, sat=0.
  - out_valid=0, out_data=0, out_count=0, out_sat=0.
  - in_ready goes to 1 on the first clk after rst_n deasserts.
- Accept/transfer rules:
  - in beat accepted when in_valid && in_ready.
  - out transfer when out_valid && out_ready.
  - Upstream may hold in_data/in_last stable while in_valid=1 and in_ready=0; the block ignores them.
- Datapath:
  - sum_c = L32_adder(acc, in_data), combinational.
  - End-around carry is implicit, so 0xFFFFFFFF+1 = 0x00000001 and 0x80000000+0x80000000 = 0x00000001.
  - acc holds raw (non-normalised) values; normalisation is applied only to out_data.
- State ACC:
  - in_ready=1, out_valid=0.
  - On accept with in_last=0: acc<=sum_c; cnt<=cnt+1, saturating at 2^COUNT_W-1; sat<=1 if cnt was already at max.
  - On accept with in_last=1:
    - out_data <= norm(sum_c).
    - out_count <= sat_inc(cnt), out_sat <= sat | (cnt==max).
    - out_valid<=1, state<=HOLD.
    - acc<=0, cnt<=0, sat<=0.
  - No accept: all registers hold.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data, out_count and out_sat are stable until transfer.
  - On transfer: out_valid<=0, state<=ACC.
  - Exactly one bubble cycle is mandatory: in_ready is low during HOLD even if out_ready is high.
- Latency:
  - out_valid rises on the clk edge that accepts the last beat, i.e. one cycle after last-beat presentation.
  - Minimum frame period is frame_len+1 cycles with out_ready held high.
- Single-beat frame (in_last on first beat): out_data = norm(in_data), out_count=1.
- norm(v) = (NORMALIZE && v==32'hFFFFFFFF) ? 0 : v.
- Reset mid-frame or mid-HOLD: partial sum and pending result are discarded; no output is produced for that frame.
- Only two states (ACC, HOLD); use a single-bit state register and no other hidden state.

Test Plan:
- Frame {3,5,last 7}, out_ready=1 -> out_data=0x0000000F, out_count=3, out_sat=0; out_valid high one cycle after the last beat; in_ready low that cycle.
- Frame {0xFFFFFFFF, last 0x00000001} -> out_data=0x00000001, out_count=2.
- Frame {0xFFFFFFFE, last 0x00000001} -> NORMALIZE=1: out_data=0x00000000; NORMALIZE=0: out_data=0xFFFFFFFF.
- Single beat {last 0x80000000} then frame {0x80000000, last 0x80000000}, out_ready=1 -> first result 0x80000000, count 1; second result 0x00000001, count 2; no carry-over of acc between frames.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_valid, out_data, out_count stable; in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
- COUNT_W=2, frame of 5 ones -> out_data=0x00000005, out_count=3, out_sat=1. Then assert rst_n=0 after 2 beats of the next frame -> outputs return to reset values immediately; a following frame {1, last 1} gives out_data=2, out_count=2.
